// File: rtl/norm_shift_arbiter.sv
// norm_shift_arbiter: round-robin sequencer for the shared 25-bit normalization
// shifter. Two requesters (0 = adder path, 1 = multiplier path) hand over
// unnormalized mantissa/exponent pairs; the block counts leading zeros, drives
// the external combinational shifter for one cycle and holds the normalized
// result until the rounding stage takes it.
//
// Build option: define NORM_SHIFT_DENORM_EN to produce denormals on exponent
// underflow; leave it undefined to flush underflowing results to zero.
module norm_shift_arbiter #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [24:0]      req0_mant,
  input  logic [EXP_W-1:0] req0_exp,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [24:0]      req1_mant,
  input  logic [EXP_W-1:0] req1_exp,
  output logic [24:0]      sh_in,
  output logic [4:0]       sh_sel,
  input  logic [24:0]      sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [24:0]      res_mant,
  output logic [EXP_W-1:0] res_exp,
  output logic             res_src,
  output logic             res_zero,
  output logic             res_uflow
);

  // Compare width wide enough for both the leading-zero count and the exponent.
  localparam int CW = (EXP_W > 5) ? EXP_W : 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Priority pointer: 0 means requester 0 wins a tie, 1 means requester 1 wins.
  logic ptr_reg;

  // Operand captured on accept.
  logic [24:0]      mant_reg;
  logic [EXP_W-1:0] exp_reg;
  logic             src_reg;

  // Result registers, loaded at the end of SHIFT.
  logic             res_valid_reg;
  logic [24:0]      res_mant_reg;
  logic [EXP_W-1:0] res_exp_reg;
  logic             res_src_reg;
  logic             res_zero_reg;
  logic             res_uflow_reg;

  logic             gnt0, gnt1;
  logic [24:0]      lead_oh;
  logic [4:0]       lzc;
  logic             mant_zero;
  logic [CW-1:0]    lzc_ext, exp_ext;
  logic             uflow_calc;
  logic [4:0]       sel_calc;
  logic [24:0]      res_mant_next;
  logic [EXP_W-1:0] res_exp_next;

  // Round-robin arbitration between the two valid inputs.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && (!req1_valid || !ptr_reg)) begin
      gnt0 = 1'b1;
    end else if (req1_valid) begin
      gnt1 = 1'b1;
    end
  end

  // One-hot marker of the leading one: a bit is the leader if nothing above it is set.
  genvar gi;
  generate
    for (gi = 0; gi < 25; gi++) begin : g_lead
      if (gi == 24) begin : g_top
        assign lead_oh[gi] = mant_reg[24];
      end else begin : g_low
        assign lead_oh[gi] = mant_reg[gi] & ~|mant_reg[24:gi+1];
      end
    end
  endgenerate

  assign mant_zero = ~|mant_reg;

  // Encode the leading-one position into a leading-zero count (25 = all zero).
  always_comb begin
    lzc = 5'd25;
    for (int i = 0; i < 25; i++) begin
      if (lead_oh[i]) begin
        lzc = 5'(24 - i);
      end
    end
  end

  assign lzc_ext    = CW'(lzc);
  assign exp_ext    = CW'(exp_reg);
  assign uflow_calc = !mant_zero && (lzc_ext >= exp_ext);

  // Shift amount and result values for the three cases: zero, normal, underflow.
  // res_mant_next picks up sh_out, which only reflects sel_calc during SHIFT.
  always_comb begin
    sel_calc      = 5'd0;
    res_mant_next = '0;
    res_exp_next  = '0;
    if (mant_zero) begin
      sel_calc = 5'd0;
    end else if (!uflow_calc) begin
      sel_calc      = lzc;
      res_mant_next = sh_out;
      res_exp_next  = exp_reg - lzc_ext[EXP_W-1:0];
    end else begin
`ifdef NORM_SHIFT_DENORM_EN
      // Underflow guarantees exp <= 24, so the low five bits are the full value.
      sel_calc      = exp_ext[4:0];
      res_mant_next = sh_out;
`else
      sel_calc      = 5'd0;
      res_mant_next = '0;
`endif
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic plus the handshake and shifter-select outputs.
  always_comb begin
    state_next = state_reg;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sh_sel     = 5'd0;
    case (state_reg)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        if (gnt0 || gnt1) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sh_sel     = sel_calc;
        state_next = HOLD;
      end
      HOLD: begin
        if (res_valid_reg && res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, pointer update and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg       <= 1'b0;
      mant_reg      <= '0;
      exp_reg       <= '0;
      src_reg       <= 1'b0;
      res_valid_reg <= 1'b0;
      res_mant_reg  <= '0;
      res_exp_reg   <= '0;
      res_src_reg   <= 1'b0;
      res_zero_reg  <= 1'b0;
      res_uflow_reg <= 1'b0;
    end else begin
      if (req0_ready || req1_ready) begin
        mant_reg <= req1_ready ? req1_mant : req0_mant;
        exp_reg  <= req1_ready ? req1_exp : req0_exp;
        src_reg  <= req1_ready;
        ptr_reg  <= req0_ready;
      end
      if (state_reg == SHIFT) begin
        res_valid_reg <= 1'b1;
        res_mant_reg  <= res_mant_next;
        res_exp_reg   <= res_exp_next;
        res_src_reg   <= src_reg;
        res_zero_reg  <= mant_zero;
        res_uflow_reg <= uflow_calc;
      end
      if ((state_reg == HOLD) && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign sh_in     = mant_reg;
  assign res_valid = res_valid_reg;
  assign res_mant  = res_mant_reg;
  assign res_exp   = res_exp_reg;
  assign res_src   = res_src_reg;
  assign res_zero  = res_zero_reg;
  assign res_uflow = res_uflow_reg;

endmodule

// File: tb/tb_norm_shift_arbiter.sv
// Bench for norm_shift_arbiter: directed cases followed by random traffic,
// compared against a behavioural model of arbitration and normalization.
module tb_norm_shift_arbiter;

  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready;
  logic [24:0]   req0_mant;
  logic [EW-1:0] req0_exp;
  logic          req1_valid, req1_ready;
  logic [24:0]   req1_mant;
  logic [EW-1:0] req1_exp;
  logic [24:0]   sh_in;
  logic [4:0]    sh_sel;
  logic [24:0]   sh_out;
  logic          res_valid, res_ready;
  logic [24:0]   res_mant;
  logic [EW-1:0] res_exp;
  logic          res_src, res_zero, res_uflow;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;
  int txn_id   = 0;

  norm_shift_arbiter #(.EXP_W(EW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mant(req0_mant), .req0_exp(req0_exp),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mant(req1_mant), .req1_exp(req1_exp),
    .sh_in(sh_in), .sh_sel(sh_sel), .sh_out(sh_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mant(res_mant), .res_exp(res_exp),
    .res_src(res_src), .res_zero(res_zero), .res_uflow(res_uflow)
  );

  always #5 clk = ~clk;

  // External combinational left shifter.
  assign sh_out = sh_in << sh_sel;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, act, exp, txn_id);
    end
  endtask

  // Normalization rules from plain arithmetic on the operand.
  task automatic ref_norm(input logic [24:0] m, input logic [7:0] e,
                          output logic [4:0] sel, output logic [24:0] rm,
                          output logic [7:0] re, output logic z, output logic u);
    int lz = 0;
    while (lz < 25) begin
      if (m[24-lz]) break;
      lz++;
    end
    sel = 5'd0; rm = '0; re = '0; z = 1'b0; u = 1'b0;
    if (m == 25'd0) begin
      z = 1'b1;
    end else if (lz < int'(e)) begin
      sel = 5'(lz);
      rm  = m << lz;
      re  = 8'(int'(e) - lz);
    end else begin
      u = 1'b1;
`ifdef NORM_SHIFT_DENORM_EN
      sel = 5'(e);
      rm  = m << e;
`endif
    end
  endtask

  task automatic drive_junk();
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    req0_mant  = 25'($urandom);
    req1_mant  = 25'($urandom);
    req0_exp   = 8'($urandom);
    req1_exp   = 8'($urandom);
  endtask

  // One IDLE cycle with the given requests; if something is granted, follow it
  // through SHIFT and HOLD (stall extra cycles of res_ready low) back to IDLE.
  task automatic run_txn(input bit v0, input logic [24:0] m0, input logic [7:0] e0,
                         input bit v1, input logic [24:0] m1, input logic [7:0] e1,
                         input int stall);
    int g;
    logic [24:0] lm, xm;
    logic [7:0]  le, xe;
    logic [4:0]  xs;
    logic        xz, xu;
    @(negedge clk);
    req0_valid = v0; req0_mant = m0; req0_exp = e0;
    req1_valid = v1; req1_mant = m1; req1_exp = e1;
    res_ready  = 1'($urandom);
    if (v0 && v1) g = ptr_m;
    else if (v0) g = 0;
    else if (v1) g = 1;
    else g = -1;
    #1;
    check_eq("idle_res_valid", 32'(res_valid), 0);
    check_eq("req0_ready", 32'(req0_ready), 32'(g == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(g == 1));
    if (g < 0) return;
    lm = (g == 1) ? m1 : m0;
    le = (g == 1) ? e1 : e0;
    ptr_m = 1 - g;
    ref_norm(lm, le, xs, xm, xe, xz, xu);
    // SHIFT cycle
    @(negedge clk);
    drive_junk();
    #1;
    check_eq("shift_sh_sel", 32'(sh_sel), 32'(xs));
    check_eq("shift_sh_in", 32'(sh_in), 32'(lm));
    check_eq("shift_res_valid", 32'(res_valid), 0);
    check_eq("shift_readys", 32'({req0_ready, req1_ready}), 0);
    // HOLD cycles
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      drive_junk();
      res_ready = (i == stall);
      #1;
      check_eq("hold_res_valid", 32'(res_valid), 1);
      check_eq("res_mant", 32'(res_mant), 32'(xm));
      check_eq("res_exp", 32'(res_exp), 32'(xe));
      check_eq("res_src", 32'(res_src), 32'(g));
      check_eq("res_zero", 32'(res_zero), 32'(xz));
      check_eq("res_uflow", 32'(res_uflow), 32'(xu));
      check_eq("hold_readys", 32'({req0_ready, req1_ready}), 0);
      check_eq("hold_sh_sel", 32'(sh_sel), 0);
    end
    $display("txn %0d: src=%0d mant=%h exp=%0d -> mant=%h exp=%0d zero=%0d uflow=%0d stall=%0d",
             txn_id, g, lm, le, res_mant, res_exp, res_zero, res_uflow, stall);
    txn_id++;
  endtask

  // Accept a request, then assert reset during SHIFT: no result, pointer back at req0.
  task automatic reset_in_shift();
    @(negedge clk);
    req0_valid = 1'b1; req0_mant = 25'h0123456; req0_exp = 8'd50;
    req1_valid = 1'b0;
    #1;
    check_eq("rs_accept_req0", 32'(req0_ready), 1);
    ptr_m = 1;
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("rs_shift_res_valid", 32'(res_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    ptr_m = 0;
    #1;
    check_eq("rs_res_valid", 32'(res_valid), 0);
    check_eq("rs_req0_ready", 32'(req0_ready), 1);
    check_eq("rs_req1_ready", 32'(req1_ready), 0);
    check_eq("rs_sh_sel", 32'(sh_sel), 0);
    check_eq("rs_sh_in", 32'(sh_in), 0);
    // Drop both valids before the edge so nothing is latched.
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("txn %0d: reset during SHIFT", txn_id);
    txn_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [24:0] rm0, rm1;
    logic [7:0]  re0, re1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_mant = '0; req1_mant = '0; req0_exp = '0; req1_exp = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_res_mant", 32'(res_mant), 0);
    check_eq("rst_res_exp", 32'(res_exp), 0);
    check_eq("rst_res_src", 32'(res_src), 0);
    check_eq("rst_res_zero", 32'(res_zero), 0);
    check_eq("rst_res_uflow", 32'(res_uflow), 0);
    check_eq("rst_sh_in", 32'(sh_in), 0);
    check_eq("rst_sh_sel", 32'(sh_sel), 0);
    check_eq("rst_readys", 32'({req0_ready, req1_ready}), 0);
    rst = 1'b0;

    // Single request
    run_txn(1'b1, 25'h0000001, 8'd30, 1'b0, 25'h0, 8'd0, 0);
    // Contention: pointer currently at req1 after the single req0 grant; reset it first
    reset_in_shift();
    run_txn(1'b1, 25'h0400000, 8'd20, 1'b1, 25'h0800000, 8'd10, 0);
    run_txn(1'b1, 25'h0400000, 8'd20, 1'b1, 25'h0800000, 8'd10, 0);
    run_txn(1'b1, 25'h1ABCDEF, 8'd77, 1'b1, 25'h0000F00, 8'd40, 1);
    run_txn(1'b1, 25'h0001234, 8'd200, 1'b1, 25'h0000003, 8'd90, 0);
    // Zero mantissa
    run_txn(1'b0, 25'h0, 8'd0, 1'b1, 25'h0000000, 8'd100, 0);
    // Underflow
    run_txn(1'b1, 25'h0000100, 8'd10, 1'b0, 25'h0, 8'd0, 0);
    // Backpressure, then a pending request
    run_txn(1'b0, 25'h0, 8'd0, 1'b1, 25'h0000ABC, 8'd60, 5);
    run_txn(1'b1, 25'h0F00000, 8'd3, 1'b1, 25'h0000010, 8'd25, 0);
    // Reset during SHIFT, then contended request must go to req0
    reset_in_shift();
    run_txn(1'b1, 25'h1000000, 8'd1, 1'b1, 25'h0000001, 8'd24, 2);

    // Random traffic
    for (int t = 0; t < 250; t++) begin
      rm0 = ($urandom_range(0, 9) == 0) ? 25'd0 : (25'($urandom) >> $urandom_range(0, 24));
      rm1 = ($urandom_range(0, 9) == 0) ? 25'd0 : (25'($urandom) >> $urandom_range(0, 24));
      re0 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 26)) : 8'($urandom);
      re1 = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 26)) : 8'($urandom);
      run_txn(1'($urandom_range(0, 3) != 0), rm0, re0,
              1'($urandom_range(0, 3) != 0), rm1, re1, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
